// File: rtl/microc_stack_dp.sv
// microc_stack_dp: microc datapath (PC, register file, ALU, zero flag) with a hardware return stack
// Ports:
//   clk, reset (async, active-low)
//   instr          instruction word at address pc (combinational ROM read)
//   s_inc          1: pc+1, 0: jump to target
//   s_inm          1: write back immediate, 0: write back ALU result
//   we, wez        register-file / zero-flag write enables
//   alu_op         ALU operation select
//   s_push, s_pop  subroutine call / return strobes
//   pc, opcode     program counter and instruction opcode field
//   zero           registered zero flag
//   stk_level      entries on the return stack
//   stk_ovf/unf    sticky overflow / underflow flags
module microc_stack_dp #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 10,
    parameter int REG_AW      = 4,
    parameter int INSTR_W     = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [INSTR_W-1:0]                 instr,
    input  logic                               s_inc,
    input  logic                               s_inm,
    input  logic                               we,
    input  logic                               wez,
    input  logic [2:0]                         alu_op,
    input  logic                               s_push,
    input  logic                               s_pop,
    output logic [PC_W-1:0]                    pc,
    output logic [5:0]                         opcode,
    output logic                               zero,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_level,
    output logic                               stk_ovf,
    output logic                               stk_unf
);
    localparam int NREG  = 2 ** REG_AW;
    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int SP_W  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;

    logic [DATA_W-1:0] regs [NREG];
    logic [PC_W-1:0]   stk  [STACK_DEPTH];
    logic [REG_AW-1:0] ra, rb, rd;
    logic [DATA_W-1:0] imm, a, b, alu_y;
    logic [PC_W-1:0]   target, pc_inc;
    logic [SP_W-1:0]   top_idx, push_idx;
    logic              stk_full, stk_empty;

    assign opcode    = instr[INSTR_W-1 -: 6];
    assign ra        = instr[3*REG_AW-1 -: REG_AW];
    assign rb        = instr[2*REG_AW-1 -: REG_AW];
    assign rd        = instr[REG_AW-1:0];
    assign imm       = instr[DATA_W+REG_AW-1:REG_AW];
    assign target    = instr[PC_W-1:0];
    assign pc_inc    = pc + 1'b1;
    assign a         = ra == '0 ? '0 : regs[ra];
    assign b         = rb == '0 ? '0 : regs[rb];
    assign stk_full  = stk_level == LVL_W'(STACK_DEPTH);
    assign stk_empty = stk_level == '0;
    // Stack grows upward: level-1 is the top entry, level is the next free slot.
    assign top_idx   = SP_W'(stk_level - 1'b1);
    assign push_idx  = SP_W'(stk_level);

    always_comb begin
        alu_y = '0;
        case (alu_op)
            3'b000:  alu_y = a;
            3'b001:  alu_y = ~a;
            3'b010:  alu_y = a + b;
            3'b011:  alu_y = a - b;
            3'b100:  alu_y = a & b;
            3'b101:  alu_y = a | b;
            3'b110:  alu_y = '0 - a;
            default: alu_y = '0 - b;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            zero      <= 1'b0;
            stk_level <= '0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
        end else begin
            if (we && rd != '0) regs[rd] <= s_inm ? imm : alu_y;
            if (wez) zero <= alu_y == '0;
            // Simultaneous push and pop is defined as a no-op on PC, stack and flags.
            if (!(s_push && s_pop)) begin
                if (s_pop) begin
                    if (!stk_empty) begin
                        pc        <= stk[top_idx];
                        stk_level <= stk_level - 1'b1;
                    end else begin
                        stk_unf <= 1'b1;
                    end
                end else if (s_push) begin
                    if (!stk_full) begin
                        stk[push_idx] <= pc_inc;
                        pc            <= target;
                        stk_level     <= stk_level + 1'b1;
                    end else begin
                        stk_ovf <= 1'b1;
                    end
                end else begin
                    pc <= s_inc ? pc_inc : target;
                end
            end
        end
    end
endmodule

// File: tb/tb_microc_stack_dp.sv
// tb_microc_stack_dp: directed and random checks of microc_stack_dp against a behavioural model
module tb_microc_stack_dp;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        s_inc = 1'b0, s_inm = 1'b0, we = 1'b0, wez = 1'b0, s_push = 1'b0, s_pop = 1'b0;
    logic [2:0]  alu_op = '0;
    logic [9:0]  pc;
    logic [5:0]  opcode;
    logic        zero, stk_ovf, stk_unf;
    logic [2:0]  stk_level;

    microc_stack_dp dut (
        .clk(clk), .reset(reset), .instr(instr), .s_inc(s_inc), .s_inm(s_inm),
        .we(we), .wez(wez), .alu_op(alu_op), .s_push(s_push), .s_pop(s_pop),
        .pc(pc), .opcode(opcode), .zero(zero), .stk_level(stk_level),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int m_r [16];
    int m_pc, m_zero, m_ovf, m_unf;
    int m_stk [$];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        foreach (m_r[i]) m_r[i] = 0;
        m_pc = 0; m_zero = 0; m_ovf = 0; m_unf = 0;
        m_stk.delete();
    endfunction

    function automatic void m_step();
        int ra = int'(instr[11:8]);
        int rb = int'(instr[7:4]);
        int rd = int'(instr[3:0]);
        int imm = int'(instr[11:4]);
        int tgt = int'(instr[9:0]);
        int a = ra == 0 ? 0 : m_r[ra];
        int b = rb == 0 ? 0 : m_r[rb];
        int y;
        case (alu_op)
            3'd0: y = a;
            3'd1: y = ~a;
            3'd2: y = a + b;
            3'd3: y = a - b;
            3'd4: y = a & b;
            3'd5: y = a | b;
            3'd6: y = -a;
            default: y = -b;
        endcase
        y = y & 255;
        if (we && rd != 0) m_r[rd] = s_inm ? imm : y;
        if (wez) m_zero = y == 0 ? 1 : 0;
        if (!(s_push && s_pop)) begin
            if (s_pop) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else m_unf = 1;
            end else if (s_push) begin
                if (m_stk.size() < 4) begin
                    m_stk.push_back((m_pc + 1) % 1024);
                    m_pc = tgt;
                end else m_ovf = 1;
            end else m_pc = s_inc ? (m_pc + 1) % 1024 : tgt;
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
        check("pc", pc, m_pc);
        check("zero", zero, m_zero);
        check("level", stk_level, m_stk.size());
        check("ovf", stk_ovf, m_ovf);
        check("unf", stk_unf, m_unf);
        check("opcode", opcode, int'(instr[15:10]));
    endtask

    task automatic apply(input logic [15:0] i, input logic inc, input logic inm, input logic w,
                         input logic wz, input logic [2:0] op, input logic push, input logic pop);
        instr = i; s_inc = inc; s_inm = inm; we = w; wez = wz; alu_op = op; s_push = push; s_pop = pop;
        cyc();
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            instr  = 16'($urandom);
            s_inc  = 1'($urandom);
            s_inm  = 1'($urandom);
            we     = 1'($urandom);
            wez    = 1'($urandom);
            alu_op = 3'($urandom);
            s_push = $urandom_range(0, 3) == 0;
            s_pop  = $urandom_range(0, 3) == 0;
            cyc();
        end
    endtask

    initial begin
        m_reset();
        #1;
        check("rst_pc", pc, 0);
        check("rst_zero", zero, 0);
        check("rst_level", stk_level, 0);
        check("rst_ovf", stk_ovf, 0);
        check("rst_unf", stk_unf, 0);
        #2 reset = 1'b1;

        apply(16'h0051, 1, 1, 1, 0, 3'b000, 0, 0);
        check("ld_pc", pc, 1);
        apply(16'h0052, 1, 1, 1, 0, 3'b000, 0, 0);
        apply(16'h0123, 1, 0, 1, 1, 3'b011, 0, 0);
        check("sub_zero", zero, 1);
        apply(16'h0123, 1, 0, 1, 1, 3'b010, 0, 0);
        check("add_zero", zero, 0);
        apply(16'h0FF0, 1, 1, 1, 0, 3'b000, 0, 0);
        apply(16'h0000, 1, 0, 0, 1, 3'b000, 0, 0);
        check("r0_zero", zero, 1);
        apply(16'h0337, 1, 0, 0, 1, 3'b000, 0, 0);
        check("r3_nonzero", zero, 0);

        apply(16'h0007, 0, 0, 0, 0, 3'b000, 0, 0);
        check("jmp_pc", pc, 7);
        apply(16'h0100, 0, 0, 0, 0, 3'b000, 1, 0);
        check("call_pc", pc, 'h100);
        check("call_level", stk_level, 1);
        apply(16'h0000, 0, 0, 0, 0, 3'b000, 0, 1);
        check("ret_pc", pc, 8);
        check("ret_level", stk_level, 0);

        for (int k = 1; k <= 4; k++) apply(16'(k * 16), 0, 0, 0, 0, 3'b000, 1, 0);
        apply(16'h0050, 0, 0, 0, 0, 3'b000, 1, 0);
        check("ovf_pc", pc, 'h40);
        check("ovf_flag", stk_ovf, 1);
        check("ovf_level", stk_level, 4);
        for (int k = 0; k < 4; k++) apply(16'h0000, 1, 0, 0, 0, 3'b000, 0, 1);
        check("pop4_pc", pc, 9);
        apply(16'h0000, 1, 0, 0, 0, 3'b000, 0, 1);
        check("unf_pc", pc, 9);
        check("unf_flag", stk_unf, 1);

        apply(16'h03FF, 0, 0, 0, 0, 3'b000, 0, 0);
        apply(16'h0000, 1, 0, 0, 0, 3'b000, 0, 0);
        check("wrap_pc", pc, 0);
        apply(16'h0200, 0, 0, 0, 0, 3'b000, 1, 0);
        apply(16'h0123, 1, 0, 0, 0, 3'b000, 1, 1);
        check("both_pc", pc, 'h200);
        check("both_level", stk_level, 1);

        rand_cycles(300);

        #3 reset = 1'b0;
        #1;
        m_reset();
        check("mrst_pc", pc, 0);
        check("mrst_zero", zero, 0);
        check("mrst_level", stk_level, 0);
        check("mrst_ovf", stk_ovf, 0);
        check("mrst_unf", stk_unf, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rand_cycles(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
